// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the boot-time program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_word_packer
// Description : Packs accepted bytes into little-endian words; pulses
//               o_word_valid in the cycle the final byte of a word is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_word_packer
  import prog_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_accept,
  input  logic [7:0]                    i_data,
  output logic [8*BYTES_PER_WORD-1:0]   o_word,
  output logic                          o_word_valid
);

  localparam int unsigned c_CNT_W = $clog2(BYTES_PER_WORD);

  logic [c_CNT_W-1:0]              r_byte_cnt;
  logic [8*(BYTES_PER_WORD-1)-1:0] r_shift;
  logic                            w_last;

  assign w_last = (r_byte_cnt == c_CNT_W'(BYTES_PER_WORD - 1));

  // The final byte is never stored; it is spliced straight into the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else if (i_accept) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
      if (!w_last) begin
        r_shift[8*r_byte_cnt +: 8] <= i_data;
      end
    end
  end

  assign o_word       = {i_data, r_shift};
  assign o_word_valid = i_accept & w_last;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Loads a length-prefixed byte stream into RAM as 32-bit words
//               and holds the CPU in reset until the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_cpu_reset,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned c_IDX_W = $clog2(MEM_DEPTH) + 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_n;
  logic [c_IDX_W-1:0] r_word_idx;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_cpu_reset;
  logic               r_done;
  logic               r_error;

  logic               w_accept;
  logic [31:0]        w_word;
  logic               w_word_valid;
  logic               w_last_word;

  assign o_in_ready  = (r_state == ST_HDR) || (r_state == ST_DATA);
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_last_word = ((32'(r_word_idx) + 32'd1) == r_n);

  prog_loader_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_accept     (w_accept),
    .i_data       (i_in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HDR: begin
        if (w_word_valid) begin
          if (w_word == 32'd0)                  w_state_next = ST_DONE;
          else if (w_word > 32'(MEM_DEPTH))     w_state_next = ST_ERR;
          else                                  w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_valid && w_last_word) w_state_next = ST_DONE;
      end
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_HDR;
    else       r_state <= w_state_next;
  end

  // Release is delayed one edge past entering DONE so the last write lands first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n         <= '0;
      r_word_idx  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_HDR: begin
          if (w_word_valid) r_n <= w_word;
          if (w_state_next == ST_ERR) r_error <= 1'b1;
        end
        ST_DATA: begin
          if (w_word_valid) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= 32'(r_word_idx) << 2;
            r_mem_wdata <= w_word;
            r_word_idx  <= r_word_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_cpu_reset <= 1'b0;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_reset = r_cpu_reset;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule
`default_nettype wire
